// File: rtl/morse_tx_serializer_if.sv
// morse_tx_serializer_if: letter request handshake (valid/ready, length, pattern).
// master drives the request, slave is the serializer.
interface morse_tx_serializer_if #(
  parameter int MAX_ELEMS = 5
);
  logic                 sym_valid;
  logic                 sym_ready;
  logic [2:0]           sym_len;
  logic [MAX_ELEMS-1:0] sym_pat;

  modport master (
    output sym_valid,
    output sym_len,
    output sym_pat,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_len,
    input  sym_pat,
    output sym_ready
  );
endinterface

// File: rtl/morse_tx_serializer.sv
// morse_tx_serializer: Morse letters in, on/off-keyed serial stream out.
// Optional MORSE_TX_SOS_EN adds sos_req, which sends S, O, S, word space.
module morse_tx_serializer #(
  parameter int MAX_ELEMS = 5,
  parameter int UNIT_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  morse_tx_serializer_if.slave sym,
`ifdef MORSE_TX_SOS_EN
  input  logic sos_req,
`endif
  output logic tx_bit,
  output logic busy,
  output logic sym_done
);
  localparam int EW = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, MARK, ESPACE, LGAP, WGAP
  } state_t;

  state_t               state;
  logic [UW-1:0]        ucnt;
  logic [1:0]           ul;
  logic [EW-1:0]        ecnt;
  logic [MAX_ELEMS-1:0] pat;

  logic                 tick;
  logic                 last;
  logic                 gap;
  logic                 accept;
  logic                 start;
  logic                 sd_base;
  logic                 sd_next;
  logic [2:0]           len_c;
  logic [2:0]           ld_len;
  logic [MAX_ELEMS-1:0] ld_pat;

  assign tick = (ucnt == UW'(UNIT_CYC - 1));
  assign last = tick && (ul == 2'd0);
  assign gap  = (state == LGAP) || (state == WGAP);

  assign len_c = (sym.sym_len > 3'(MAX_ELEMS))
               ? 3'(MAX_ELEMS) : sym.sym_len;

  // sym_done is registered, so it is raised one cycle ahead of the last gap cycle
  assign sd_base = gap && !last &&
    ((tick && (ul == 2'd1) && (UNIT_CYC == 1)) ||
     (!tick && (ul == 2'd0) &&
      ((int'(ucnt) + 1) == (UNIT_CYC - 1))));

`ifdef MORSE_TX_SOS_EN
  logic       sos_act;
  logic [1:0] sos_step;
  logic       sos_go;
  logic       sos_next;

  assign sym.sym_ready = rst && !sos_act &&
    ((state == IDLE) || (gap && last));
  assign sos_go   = sos_req && sym.sym_ready;
  assign sos_next = sos_act && (state == LGAP) && last;
  assign accept   = sym.sym_valid && sym.sym_ready && !sos_req;
  assign sd_next  = sd_base && (!sos_act || (state == WGAP));
`else
  assign sym.sym_ready = rst &&
    ((state == IDLE) || (gap && last));
  assign accept  = sym.sym_valid && sym.sym_ready;
  assign sd_next = sd_base;
`endif

  always_comb begin
    start  = accept;
    ld_len = len_c;
    ld_pat = sym.sym_pat;
`ifdef MORSE_TX_SOS_EN
    unique case (1'b1)
      sos_go: begin
        start  = 1'b1;
        ld_len = 3'd3;
        ld_pat = '0;
      end
      sos_next: begin
        start = 1'b1;
        unique case (sos_step)
          2'd1: begin
            ld_len = 3'd3;
            ld_pat = MAX_ELEMS'(3'b111);
          end
          2'd2: begin
            ld_len = 3'd3;
            ld_pat = '0;
          end
          default: begin
            ld_len = 3'd0;
            ld_pat = '0;
          end
        endcase
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tx_bit   <= 1'b0;
      busy     <= 1'b0;
      sym_done <= 1'b0;
      ucnt     <= '0;
      ul       <= '0;
      ecnt     <= '0;
      pat      <= '0;
`ifdef MORSE_TX_SOS_EN
      sos_act  <= 1'b0;
      sos_step <= '0;
`endif
    end else begin
      sym_done <= sd_next;
      if (start) begin
        ucnt <= '0;
        pat  <= ld_pat;
        busy <= 1'b1;
        if (ld_len == 3'd0) begin
          state  <= WGAP;
          ul     <= 2'd3;
          tx_bit <= 1'b0;
        end else begin
          state  <= MARK;
          ecnt   <= EW'(ld_len - 3'd1);
          ul     <= ld_pat[ld_len - 3'd1] ? 2'd2 : 2'd0;
          tx_bit <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (!tick) begin
          ucnt <= ucnt + 1'b1;
        end else begin
          ucnt <= '0;
          if (ul != 2'd0) begin
            ul <= ul - 2'd1;
          end else begin
            unique case (state)
              MARK: begin
                tx_bit <= 1'b0;
                if (ecnt == '0) begin
                  state <= LGAP;
                  ul    <= 2'd2;
                end else begin
                  state <= ESPACE;
                  ecnt  <= ecnt - 1'b1;
                end
              end
              ESPACE: begin
                state  <= MARK;
                ul     <= pat[ecnt] ? 2'd2 : 2'd0;
                tx_bit <= 1'b1;
              end
              default: begin
                state  <= IDLE;
                busy   <= 1'b0;
                tx_bit <= 1'b0;
              end
            endcase
          end
        end
      end
`ifdef MORSE_TX_SOS_EN
      if (sos_go) begin
        sos_act  <= 1'b1;
        sos_step <= 2'd1;
      end else if (sos_next) begin
        sos_step <= sos_step + 2'd1;
      end else if (sos_act && (state == WGAP) && last) begin
        sos_act  <= 1'b0;
      end
`endif
    end
  end
endmodule
